bomb_arm_ctrl: RTL and testbench
================================

BOMB_ARM_CTRL -- requirements
Module: bomb_arm_ctrl

Interface
REQ-001 Parameter CLK_DIV, 50000000, clk cycles per countdown second (>=2).
REQ-002 Parameter COUNT_INIT, 60, countdown start value in seconds (1..99).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 SW  input  7  DIP switches carrying the password being set.
REQ-006 BTN7  input  1  confirm/arm button, level, already debounced.
REQ-007 success  input  1  defuse indication from the password-check block.
REQ-008 psw  output  7  latched correct password, fed to the password-check block.
REQ-009 startInput  output  7->1  input-enable to the password-check block (1 bit).
REQ-010 sec_left  output  7  seconds remaining, binary.
REQ-011 defused  output  1  bomb defused flag.
REQ-012 exploded  output  1  bomb exploded flag.

Function
REQ-013 The block SHALL implement states IDLE, ARMED, DEFUSED and EXPLODED; all outputs registered.
REQ-014 BTN7 edge SHALL be detected as BTN7=1 with the previous sampled value 0; the previous-value register resets to 1, so a button held through reset does not arm.
REQ-015 In IDLE: psw=0, startInput=0, sec_left=COUNT_INIT, defused=0, exploded=0; SW and success otherwise ignored.
REQ-016 IDLE -> ARMED on a BTN7 edge with SW!=0: on that same edge psw<=SW, startInput<=1, prescaler<=0.
REQ-017 A BTN7 edge with SW==0 SHALL be rejected; state stays IDLE.
REQ-018 In ARMED the prescaler SHALL count 0..CLK_DIV-1 and wrap; a wrap is a tick; the first tick occurs exactly CLK_DIV cycles after the arming edge.
REQ-019 On each tick in ARMED, sec_left SHALL decrement by 1; no wrap below 0.
REQ-020 On a tick with sec_left==1: sec_left<=0, state<=EXPLODED, exploded<=1, startInput<=0, all on the same edge.
REQ-021 ARMED with success=1 sampled: state<=DEFUSED, defused<=1, startInput<=0; sec_left holds its current value.
REQ-022 success and the final tick in the same cycle: success wins; DEFUSED, sec_left stays 1, exploded stays 0.
REQ-023 In ARMED, psw SHALL be frozen and BTN7 and SW ignored.
REQ-024 DEFUSED and EXPLODED SHALL be terminal: outputs frozen, all inputs except rst ignored.
REQ-025 success SHALL be ignored in every state other than ARMED.
REQ-026 defused and exploded SHALL never be 1 simultaneously.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL enter IDLE and drive the REQ-015 values, prescaler=0, and previous-button register=1 on that edge.
REQ-028 rst SHALL take priority over every other input in every state, including mid-countdown.

Verification (CLK_DIV=4, COUNT_INIT=3)
REQ-029 Reset: rst=1 for 2 cycles from any state -> psw=0, startInput=0, sec_left=3, defused=0, exploded=0.
REQ-030 Arm: SW=7'h2A, 1-cycle BTN7 pulse -> next cycle psw=7'h2A, startInput=1; 4 cycles later sec_left=2, then 1 after 8 cycles.
REQ-031 Timeout: arm, no success -> 12 cycles after arming sec_left=0, exploded=1, startInput=0; values hold for 20 more cycles.
REQ-032 Defuse: arm, success=1 at cycle 6 after arming -> defused=1, startInput=0, sec_left=2 frozen; later success toggles have no effect.
REQ-033 Race: success=1 on the cycle of the tick with sec_left==1 -> defused=1, exploded=0, sec_left=1.
REQ-034 Rejects: BTN7 edge with SW=0 -> stays IDLE; BTN7 held high while rst falls -> no arming until BTN7 is released and pressed again.

Source files
------------

// File: rtl/bomb_arm_ctrl.sv
// Arming/countdown controller: latches a password, counts down in seconds,
// and ends in a terminal DEFUSED or EXPLODED state. All outputs are registered.
module bomb_arm_ctrl #(
  parameter int CLK_DIV    = 50000000,
  parameter int COUNT_INIT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] SW,
  input  logic       BTN7,
  input  logic       success,
  output logic [6:0] psw,
  output logic       startInput,
  output logic [6:0] sec_left,
  output logic       defused,
  output logic       exploded
);

  // state    | meaning
  // IDLE     | waiting for a BTN7 press with a nonzero password on SW
  // ARMED    | countdown running, password-check block enabled
  // DEFUSED  | success seen while armed; terminal
  // EXPLODED | countdown reached zero; terminal
  typedef enum logic [1:0] {IDLE, ARMED, DEFUSED, EXPLODED} state_t;

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [6:0]    SEC_INIT   = 7'(COUNT_INIT);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          btn_prev_q;
  logic [6:0]    psw_d, sec_d;
  logic          start_d, def_d, exp_d;
  logic          btn_edge, tick;

  assign btn_edge = BTN7 & ~btn_prev_q;
  assign tick     = (presc_q == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      btn_prev_q <= 1'b1;  // a button held through reset must not look like a press
      psw        <= '0;
      startInput <= 1'b0;
      sec_left   <= SEC_INIT;
      defused    <= 1'b0;
      exploded   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      btn_prev_q <= BTN7;
      psw        <= psw_d;
      startInput <= start_d;
      sec_left   <= sec_d;
      defused    <= def_d;
      exploded   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    psw_d   = psw;
    start_d = startInput;
    sec_d   = sec_left;
    def_d   = defused;
    exp_d   = exploded;
    unique case (state_q)
      IDLE: begin
        psw_d   = '0;
        start_d = 1'b0;
        sec_d   = SEC_INIT;
        def_d   = 1'b0;
        exp_d   = 1'b0;
        if (btn_edge && (SW != 7'd0)) begin
          state_d = ARMED;
          psw_d   = SW;
          start_d = 1'b1;
          presc_d = '0;
        end
      end
      ARMED: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        // success outranks a simultaneous final tick
        if (success) begin
          state_d = DEFUSED;
          def_d   = 1'b1;
          start_d = 1'b0;
        end else if (tick) begin
          if (sec_left > 7'd1) begin
            sec_d = sec_left - 7'd1;
          end else begin
            sec_d   = 7'd0;
            state_d = EXPLODED;
            exp_d   = 1'b1;
            start_d = 1'b0;
          end
        end
      end
      DEFUSED, EXPLODED: begin
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bomb_arm_ctrl.sv
// Scoreboard bench for bomb_arm_ctrl: a time-based reference model pushes the
// expected outputs after every clock edge and a monitor compares on the falling edge.
module tb_bomb_arm_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int COUNT_INIT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] SW = 7'd0;
  logic       BTN7 = 1'b0;
  logic       success = 1'b0;
  logic [6:0] psw;
  logic       startInput;
  logic [6:0] sec_left;
  logic       defused;
  logic       exploded;

  bomb_arm_ctrl #(.CLK_DIV(CLK_DIV), .COUNT_INIT(COUNT_INIT)) dut (
    .clk(clk), .rst(rst), .SW(SW), .BTN7(BTN7), .success(success),
    .psw(psw), .startInput(startInput), .sec_left(sec_left),
    .defused(defused), .exploded(exploded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] psw;
    logic       start;
    logic [6:0] sec;
    logic       def;
    logic       exp;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 idle, 1 armed, 2 defused, 3 exploded. Seconds left are
  // derived from elapsed cycles since arming rather than from a prescaler.
  int   m_mode = 0;
  int   m_elapsed = 0;
  bit   m_prev = 1'b1;
  out_t m_out = '0;

  always @(posedge clk) begin
    bit edge_seen;
    int s;
    if (rst) begin
      m_mode = 0;
      m_prev = 1'b1;
      m_out  = '{psw: 7'd0, start: 1'b0, sec: 7'(COUNT_INIT), def: 1'b0, exp: 1'b0};
    end else begin
      edge_seen = BTN7 && !m_prev;
      m_prev    = BTN7;
      case (m_mode)
        0: begin
          m_out = '{psw: 7'd0, start: 1'b0, sec: 7'(COUNT_INIT), def: 1'b0, exp: 1'b0};
          if (edge_seen && SW != 7'd0) begin
            m_mode      = 1;
            m_elapsed   = 0;
            m_out.psw   = SW;
            m_out.start = 1'b1;
          end
        end
        1: begin
          m_elapsed++;
          if (success) begin
            m_mode      = 2;
            m_out.def   = 1'b1;
            m_out.start = 1'b0;
          end else begin
            s = COUNT_INIT - m_elapsed / CLK_DIV;
            m_out.sec = 7'(s);
            if (s == 0) begin
              m_mode      = 3;
              m_out.exp   = 1'b1;
              m_out.start = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
    exp_q.push_back(m_out);
  end

  always @(negedge clk) begin
    out_t e;
    out_t a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{psw: psw, start: startInput, sec: sec_left, def: defused, exp: exploded};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got psw=%h start=%b sec=%0d def=%b exp=%b, want psw=%h start=%b sec=%0d def=%b exp=%b",
                 $time, a.psw, a.start, a.sec, a.def, a.exp, e.psw, e.start, e.sec, e.def, e.exp);
      end
      checks++;
      if ((defused & exploded) !== 1'b0) begin
        errors++;
        $display("FAIL flags_exclusive t=%0t: got def=%b exp=%b, want not both 1", $time, defused, exploded);
      end
    end
  end

  task automatic drive(input bit r, input logic [6:0] s, input bit b, input bit su, input int n);
    rst = r; SW = s; BTN7 = b; success = su;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    drive(1, 7'h00, 0, 0, 2);
    // timeout, then hold, then success ignored when exploded
    drive(0, 7'h2A, 1, 0, 1);
    drive(0, 7'h2A, 0, 0, 14);
    drive(0, 7'h00, 0, 0, 20);
    drive(0, 7'h11, 1, 1, 3);
    // defuse at cycle 6 after arming, later toggles ignored
    drive(1, 7'h00, 0, 0, 2);
    drive(0, 7'h2A, 1, 0, 1);
    drive(0, 7'h2A, 0, 0, 5);
    drive(0, 7'h2A, 0, 1, 1);
    drive(0, 7'h33, 0, 0, 3);
    drive(0, 7'h33, 1, 1, 2);
    drive(0, 7'h33, 0, 0, 15);
    // success coincides with the final tick
    drive(1, 7'h00, 0, 0, 2);
    drive(0, 7'h05, 1, 0, 1);
    drive(0, 7'h05, 0, 0, 11);
    drive(0, 7'h05, 0, 1, 1);
    drive(0, 7'h05, 0, 0, 5);
    // rejects: SW==0, and a button held through reset
    drive(1, 7'h00, 0, 0, 2);
    drive(0, 7'h00, 1, 0, 1);
    drive(0, 7'h00, 0, 0, 3);
    drive(1, 7'h55, 1, 0, 2);
    drive(0, 7'h55, 1, 0, 6);
    drive(0, 7'h55, 0, 0, 1);
    drive(0, 7'h55, 1, 0, 1);
    drive(0, 7'h55, 1, 0, 16);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, b, su;
      logic [6:0] s;
      r  = ($urandom_range(0, 79) == 0);
      b  = ($urandom_range(0, 3) == 0) ? !BTN7 : BTN7;
      su = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      drive(r, s, b, su, 1);
    end
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
